i2c_cfg_slave: RTL and testbench
================================

Name: i2c_cfg_slave

Overview:
- Synchronous I2C slave that gives the trigger TDC an external configuration and status path over the SDa/SCl pins.
- Oversamples both lines on the system clock and detects START/STOP internally.
- Decodes address, register pointer and data bytes; holds NREG 8-bit configuration registers driving the TDC datapath; returns one status byte on read.

Parameters:
- I2C_ADDR, 7'h50: 7-bit slave address matched on the first byte.
- NREG, 8: number of 8-bit config registers, at pointer addresses 0..NREG-1 (NREG ≤ 255).
- FILT, 3: clock cycles a synchronized line must hold stable before its filtered value changes.
- RST_VAL, 0: reset value of every config register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- scl_in  in  1  SCL pin, asynchronous.
- sda_in  in  1  SDA pin, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- cfg_out  out  8*NREG  config registers; reg k at bits [8k+7:8k].
- stat_in  in  8  status byte, readable at pointer 8'hFF.
- wr_strobe  out  1  one-cycle pulse when a config register is written.
- wr_addr  out  8  pointer of the write; valid with wr_strobe.
- busy  out  1  1 from START to STOP.

Behaviour:
- Reset (async assert, sync release): sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, pointer=0, cfg_out all RST_VAL, state IDLE.
- Input conditioning: 2-FF synchronizer on each line, then a FILT-cycle stability filter. All events use filtered values. Edge and START/STOP flags are one-cycle pulses.
- START: filtered SDA falls while filtered SCL is 1. STOP: filtered SDA rises while filtered SCL is 1.
- START in any state: goto ADDR, bit count 0, sda_oe=0, busy=1. Covers repeated START.
- STOP in any state: goto IDLE, sda_oe=0, busy=0.
- Bits are sampled on the SCL rising pulse, MSB first. sda_oe changes only on the SCL falling pulse.
- ADDR:
  - After 8 bits, if addr[7:1]==I2C_ADDR: goto ADDR_ACK and record R/W.
  - Otherwise goto WAIT, no ACK.
- ADDR_ACK: sda_oe=1 from the falling edge after bit 8 to the next falling edge.
  - On W: goto PTR.
  - On R: load the read byte and drive its MSB on that same falling edge, goto RDATA.
- PTR: 8 bits load the pointer, then ACK as above, then goto WDATA.
- WDATA: 8 bits, then ACK.
  - The write takes effect in the cycle after the 8th rising pulse: if pointer<NREG, update cfg_out[pointer], pulse wr_strobe, set wr_addr=pointer.
  - If pointer≥NREG: no write, no strobe, ACK still given.
  - Pointer then increments mod 256. Stay in WDATA for further bytes.
- Read byte = cfg[pointer] if pointer<NREG; stat_in if pointer==8'hFF (sampled when the byte is loaded); 8'h00 otherwise.
- RDATA:
  - sda_oe = ~bit for bits 7..0.
  - Release SDA on the falling edge after bit 0, then sample master ACK on the next rising edge.
  - ACK (SDA=0): pointer++ mod 256, load the next byte, drive its MSB on the following falling edge.
  - NACK: goto WAIT with sda_oe=0.
- WAIT: sda_oe=0; ignore everything except START/STOP.
- Simultaneous conditions: STOP/START take priority over bit processing in the same cycle. A partial byte is discarded; a write lands only after its 8th bit.
- Pointer persists across transactions (write-pointer-then-repeated-START-read). It is cleared only by reset.
- Reset mid-transaction: immediate sda_oe=0 and all outputs to reset values. The bus frees on the next STOP or START.

Test Plan:
- Reset, then START, 0xA0, 0x02, 0x5A, 0xC3, STOP -> ACK on all four bytes; cfg reg2=0x5A, reg3=0xC3; two wr_strobe pulses with wr_addr 2 then 3.
- Then START, 0xA0, 0x02, repeated START, 0xA1, read 2 bytes (master ACK then NACK), STOP -> SDA returns 0x5A, 0xC3; sda_oe=0 after NACK; pointer=4.
- START, 0xA2 (wrong address), 0x11, STOP -> no ACK, sda_oe stays 0, no strobe, cfg unchanged.
- Write pointer 0xFF with stat_in=0x96, repeated START, read 2 bytes -> 0x96 then cfg reg0 (pointer wraps 0xFF→0x00).
- Write pointer 0x01, send 4 data bits, STOP -> reg1 unchanged, no strobe, busy=0. A following full write to reg1 succeeds.
- Drive reset_n=0 while sda_oe=1 during an ACK -> sda_oe=0 within the same cycle; cfg_out=RST_VAL; the next transaction works normally.

Source files
------------

// File: rtl/i2c_cfg_slave.sv
// i2c_cfg_slave: I2C slave giving the TDC a config register file and a status readback.
// Ports: clk/reset_n system clock and async active-low reset; scl_in/sda_in raw bus pins;
// sda_oe pulls SDA low; cfg_out holds NREG config bytes (reg k at [8k+7:8k]);
// stat_in is returned at pointer 8'hFF; wr_strobe/wr_addr flag each register write;
// busy is high from START to STOP.
module i2c_cfg_slave #(
    parameter logic [6:0] I2C_ADDR = 7'h50,
    parameter int         NREG     = 8,
    parameter int         FILT     = 3,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [8*NREG-1:0] cfg_out,
    input  logic [7:0]        stat_in,
    output logic              wr_strobe,
    output logic [7:0]        wr_addr,
    output logic              busy
);
    localparam int CW = $clog2(FILT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, ACK, PTR, WDATA, RDATA, RACK, WAIT} state_t;

    logic [1:0]        scl_s_q, scl_s_d, sda_s_q, sda_s_d;
    logic [CW-1:0]     scl_c_q, scl_c_d, sda_c_q, sda_c_d;
    logic              scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic              scl_p_q, scl_p_d, sda_p_q, sda_p_d;
    state_t            state_q, state_d, nxt_q, nxt_d;
    logic              ack_on_q, ack_on_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [6:0]        sh_q, sh_d;
    logic [7:0]        ptr_q, ptr_d, tx_q, tx_d, wr_addr_q, wr_addr_d;
    logic [8*NREG-1:0] cfg_q, cfg_d;
    logic              sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
    logic              scl_rise, scl_fall, start, stop;
    logic [7:0]        byte_in, rd_cur, rd_inc;

    function automatic logic [7:0] lookup(input logic [7:0] p, input logic [8*NREG-1:0] c,
                                          input logic [7:0] s);
        lookup = (p == 8'hFF) ? s : 8'h00;
        for (int k = 0; k < NREG; k++)
            if (p == 8'(k)) lookup = c[8*k +: 8];
    endfunction

    // Synchronizer plus stability filter: the filtered value only follows the
    // synchronized line once it has disagreed for FILT consecutive cycles.
    always_comb begin
        scl_s_d = {scl_s_q[0], scl_in};
        sda_s_d = {sda_s_q[0], sda_in};
        scl_p_d = scl_f_q;
        sda_p_d = sda_f_q;
        scl_f_d = scl_f_q;
        sda_f_d = sda_f_q;
        scl_c_d = '0;
        sda_c_d = '0;
        if (scl_s_q[1] != scl_f_q) begin
            if (scl_c_q == CW'(FILT - 1)) scl_f_d = scl_s_q[1];
            else scl_c_d = scl_c_q + 1'b1;
        end
        if (sda_s_q[1] != sda_f_q) begin
            if (sda_c_q == CW'(FILT - 1)) sda_f_d = sda_s_q[1];
            else sda_c_d = sda_c_q + 1'b1;
        end
    end

    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign stop     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
    assign byte_in  = {sh_q, sda_f_q};
    assign rd_cur   = lookup(ptr_q, cfg_q, stat_in);
    assign rd_inc   = lookup(ptr_q + 8'd1, cfg_q, stat_in);

    always_comb begin
        state_d     = state_q;
        nxt_d       = nxt_q;
        ack_on_d    = ack_on_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        ptr_d       = ptr_q;
        tx_d        = tx_q;
        cfg_d       = cfg_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ack_on_d = 1'b0;
        end else if (start) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
            ack_on_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = ACK;
                        if (state_q == ADDR) begin
                            // Address byte: addr[7:1] is the slave address, bit 0 is R/W.
                            state_d = (sh_q == I2C_ADDR) ? ACK : WAIT;
                            nxt_d   = sda_f_q ? RDATA : PTR;
                        end else if (state_q == PTR) begin
                            ptr_d = byte_in;
                            nxt_d = WDATA;
                        end else begin
                            for (int k = 0; k < NREG; k++)
                                if (ptr_q == 8'(k)) cfg_d[8*k +: 8] = byte_in;
                            if (int'(ptr_q) < NREG) begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                            end
                            ptr_d = ptr_q + 8'd1;
                            nxt_d = WDATA;
                        end
                    end
                end
                // First falling edge asserts ACK, the next one ends it (and for
                // reads immediately drives the MSB of the first byte).
                ACK: if (scl_fall) begin
                    ack_on_d = ~ack_on_q;
                    sda_oe_d = 1'b1;
                    if (ack_on_q) begin
                        state_d  = nxt_q;
                        cnt_d    = '0;
                        tx_d     = rd_cur;
                        sda_oe_d = (nxt_q == RDATA) ? ~rd_cur[7] : 1'b0;
                    end
                end
                // cnt counts bits already clocked out; bit 7 is driven before the first rise.
                RDATA: if (scl_rise) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall) begin
                    sda_oe_d = (cnt_q == 4'd8) ? 1'b0 : ~tx_q[~cnt_q[2:0]];
                    state_d  = (cnt_q == 4'd8) ? RACK : RDATA;
                end
                RACK: if (scl_rise) begin
                    ptr_d   = ptr_q + 8'd1;
                    tx_d    = rd_inc;
                    cnt_d   = '0;
                    state_d = sda_f_q ? WAIT : RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_s_q     <= 2'b11;
            sda_s_q     <= 2'b11;
            scl_c_q     <= '0;
            sda_c_q     <= '0;
            scl_f_q     <= 1'b1;
            sda_f_q     <= 1'b1;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            state_q     <= IDLE;
            nxt_q       <= IDLE;
            ack_on_q    <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            tx_q        <= '0;
            cfg_q       <= {NREG{RST_VAL}};
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            scl_s_q     <= scl_s_d;
            sda_s_q     <= sda_s_d;
            scl_c_q     <= scl_c_d;
            sda_c_q     <= sda_c_d;
            scl_f_q     <= scl_f_d;
            sda_f_q     <= sda_f_d;
            scl_p_q     <= scl_p_d;
            sda_p_q     <= sda_p_d;
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            ack_on_q    <= ack_on_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            tx_q        <= tx_d;
            cfg_q       <= cfg_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign cfg_out   = cfg_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_cfg_slave.sv
// tb_i2c_cfg_slave: randomized scoreboard bench driving i2c_cfg_slave as a bus master.
module tb_i2c_cfg_slave;
    localparam int NREG = 8;
    localparam int Q    = 12;

    logic              clk = 1'b0, reset_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic [7:0]        stat_in = 8'h00;
    logic              sda_oe, wr_strobe, busy, sda_bus;
    logic [7:0]        wr_addr;
    logic [8*NREG-1:0] cfg_out;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_cfg_slave #(.I2C_ADDR(7'h50), .NREG(NREG), .FILT(3), .RST_VAL(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
        .cfg_out(cfg_out), .stat_in(stat_in), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {string name; int val;} item_t;
    typedef struct {int a; int d;} wr_t;
    item_t      exp_q[$], got_q[$];
    wr_t        exp_wr[$];
    int         checks = 0, errors = 0;
    int         m_cfg[NREG];
    int         m_ptr = 0;
    logic [7:0] wbuf[8];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_cfg(input string nm);
        for (int k = 0; k < NREG; k++) chk(nm, int'(cfg_out[8*k +: 8]), m_cfg[k]);
    endtask

    function automatic int model_rd(input int p);
        return (p < NREG) ? m_cfg[p] : (p == 255) ? int'(stat_in) : 0;
    endfunction

    // Scoreboard: bus responses and register-write strobes are compared as they appear.
    always @(negedge clk) begin
        item_t g, e;
        wr_t   w;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: got %0h with nothing expected", g.name, g.val);
            end else begin
                e = exp_q.pop_front();
                if (g.val !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, g.val, e.val);
                end
            end
        end
        if (reset_n && wr_strobe) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_strobe: unexpected write addr %0h", wr_addr);
            end else begin
                w = exp_wr.pop_front();
                if (int'(wr_addr) != w.a || wr_addr >= NREG ||
                    int'(cfg_out[8*wr_addr[2:0] +: 8]) != w.d) begin
                    errors++;
                    $display("FAIL wr_strobe: got addr %0h expected addr %0h data %0h", wr_addr, w.a, w.d);
                end
            end
        end
    end

    task automatic tick; repeat (Q) @(negedge clk); endtask

    task automatic bit_io(input logic b, output logic r);
        sda_m = b; tick;
        scl_m = 1'b1; tick;
        r = sda_bus; tick;
        scl_m = 1'b0; tick;
    endtask

    task automatic start_c;
        sda_m = 1'b1; tick; scl_m = 1'b1; tick; sda_m = 1'b0; tick; scl_m = 1'b0; tick;
    endtask

    task automatic stop_c;
        sda_m = 1'b0; tick; scl_m = 1'b1; tick; sda_m = 1'b1; tick;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic r;
        exp_q.push_back('{nm, int'(exp_ack)});
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        got_q.push_back('{nm, int'(!r)});
    endtask

    task automatic recv_byte(input logic ack, input string nm);
        logic [7:0] v;
        logic r;
        exp_q.push_back('{nm, model_rd(m_ptr)});
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            v[i] = r;
        end
        bit_io(!ack, r);
        got_q.push_back('{nm, int'(v)});
        m_ptr = (m_ptr + 1) % 256;
    endtask

    task automatic wr_frame(input logic [6:0] a, input logic [7:0] p, input int n);
        logic hit;
        hit = (a == 7'h50);
        start_c;
        chk("busy_start", int'(busy), 1);
        send_byte({a, 1'b0}, hit, "addr_ack");
        send_byte(p, hit, "ptr_ack");
        if (hit) m_ptr = int'(p);
        for (int i = 0; i < n; i++) begin
            if (hit && m_ptr < NREG) begin
                m_cfg[m_ptr] = int'(wbuf[i]);
                exp_wr.push_back('{m_ptr, int'(wbuf[i])});
            end
            send_byte(wbuf[i], hit, "data_ack");
            if (hit) m_ptr = (m_ptr + 1) % 256;
        end
    endtask

    task automatic rd_frame(input int n);
        start_c;
        send_byte(8'hA1, 1'b1, "raddr_ack");
        for (int i = 0; i < n; i++) recv_byte(i < n - 1, "rd_data");
        tick;
        chk("oe_after_nack", int'(sda_oe), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        int p, n;
        for (int k = 0; k < NREG; k++) m_cfg[k] = 0;
        repeat (5) @(negedge clk);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_strobe", int'(wr_strobe), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk_cfg("rst_cfg");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        wr_frame(7'h50, 8'h02, 2);
        stop_c;
        chk("busy_stop", int'(busy), 0);
        chk_cfg("cfg_write");

        wr_frame(7'h50, 8'h02, 0);
        rd_frame(2);
        stop_c;
        rd_frame(1);
        stop_c;

        wbuf[0] = 8'h11;
        wr_frame(7'h51, 8'h11, 0);
        stop_c;
        chk_cfg("cfg_wrong_addr");

        stat_in = 8'h96;
        wr_frame(7'h50, 8'hFF, 0);
        rd_frame(2);
        stop_c;

        wr_frame(7'h50, 8'h01, 0);
        for (int i = 0; i < 4; i++) bit_io(1'(i), r);
        stop_c;
        chk("busy_partial", int'(busy), 0);
        chk_cfg("cfg_partial");
        wbuf[0] = 8'hE7;
        wr_frame(7'h50, 8'h01, 1);
        stop_c;
        chk_cfg("cfg_after_partial");

        for (int it = 0; it < 4; it++) begin
            p = $urandom_range(0, 9);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            wr_frame(7'h50, 8'(p), n);
            stop_c;
            chk_cfg("cfg_rand");
            wr_frame(7'h50, 8'(p), 0);
            rd_frame(n);
            stop_c;
        end

        start_c;
        for (int i = 7; i >= 0; i--) bit_io(i == 7 || i == 5, r);
        chk("oe_during_ack", int'(sda_oe), 1);
        reset_n = 1'b0;
        #1;
        chk("oe_reset", int'(sda_oe), 0);
        for (int k = 0; k < NREG; k++) m_cfg[k] = 0;
        m_ptr = 0;
        chk_cfg("cfg_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        stop_c;
        wbuf[0] = 8'h3C;
        wr_frame(7'h50, 8'h05, 1);
        stop_c;
        wr_frame(7'h50, 8'h05, 0);
        rd_frame(1);
        stop_c;
        chk_cfg("cfg_post_reset");

        repeat (20) @(negedge clk);
        chk("exp_bus_drained", exp_q.size(), 0);
        chk("exp_wr_drained", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
